// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address, and
// drives the IF/ID hazard control word, latched redirects and interrupt entry.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpEn,
  input  logic [31:0] JumpTarget,
  input  logic        JrEn,
  input  logic [31:0] JrTarget,
  input  logic        ExcReq,
  input  logic        Irq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] Inst,
  output logic [1:0]  HzCtrl,
  output logic [31:0] EPC_Out,
  output logic        EPC_We
);

  localparam logic [1:0] HZ_NORMAL = 2'b00;
  localparam logic [1:0] HZ_FLUSH  = 2'b01;
  localparam logic [1:0] HZ_STALL  = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        irq_pend_q, irq_pend_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;
  logic        irq_take;

  assign redir    = BranchTaken | JrEn | JumpEn;
  assign pc_plus4 = pc_q + 32'd4;

  // Branch resolves in EX, so it belongs to an older instruction than jr/j in ID.
  always_comb begin
    redir_tgt = JumpTarget;
    if (BranchTaken)
      redir_tgt = BranchTarget;
    else if (JrEn)
      redir_tgt = JrTarget;
  end

  always_comb begin
    pc_d         = pc_plus4;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    HzCtrl       = HZ_NORMAL;
    EPC_Out      = 32'd0;
    EPC_We       = 1'b0;
    irq_take     = 1'b0;

    if (ExcReq) begin
      pc_d         = EXC_VECTOR;
      redir_pend_d = 1'b0;
      HzCtrl       = HZ_FLUSH;
    end else if (Stall) begin
      pc_d   = pc_q;
      HzCtrl = HZ_STALL;
      if (redir) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = redir_tgt;
      end
    end else if (redir_pend_q) begin
      pc_d         = redir ? redir_tgt : redir_pc_q;
      redir_pend_d = 1'b0;
      HzCtrl       = HZ_FLUSH;
    end else if (redir) begin
      pc_d   = redir_tgt;
      HzCtrl = HZ_FLUSH;
    end else if (irq_pend_q && !pc_q[31]) begin
      irq_take = 1'b1;
      pc_d     = IRQ_VECTOR;
      EPC_Out  = pc_q;
      EPC_We   = 1'b1;
      HzCtrl   = HZ_FLUSH;
    end
  end

  // New requests are only sampled in user space; a pending one survives kernel mode.
  assign irq_pend_d = (irq_pend_q | (Irq & ~pc_q[31])) & ~irq_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'd0;
      irq_pend_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      irq_pend_q   <= irq_pend_d;
    end
  end

  assign PC       = pc_q;
  assign ImemAddr = pc_q;
  assign PC4      = pc_plus4;
  assign Inst     = ImemData;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan sequences followed
// by randomized traffic, all compared against a cycle-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst, Stall, BranchTaken, JumpEn, JrEn, ExcReq, Irq;
  logic [31:0] BranchTarget, JumpTarget, JrTarget, ImemData;
  logic [31:0] ImemAddr, PC, PC4, Inst, EPC_Out;
  logic [1:0]  HzCtrl;
  logic        EPC_We;

  if_fetch_unit #(
    .RESET_PC(RESET_PC), .IRQ_VECTOR(IRQ_VECTOR), .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk(clk), .rst(rst), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .JrEn(JrEn), .JrTarget(JrTarget),
    .ExcReq(ExcReq), .Irq(Irq),
    .ImemAddr(ImemAddr), .ImemData(ImemData),
    .PC(PC), .PC4(PC4), .Inst(Inst), .HzCtrl(HzCtrl),
    .EPC_Out(EPC_Out), .EPC_We(EPC_We)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model state: architectural view of the fetch stage.
  bit          m_valid = 0;
  logic [31:0] m_pc;
  bit          m_pend, m_ipend;
  logic [31:0] m_rpc;

  task automatic idle_inputs();
    rst = 0; Stall = 0; BranchTaken = 0; JumpEn = 0; JrEn = 0; ExcReq = 0; Irq = 0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; JrTarget = 32'h0;
  endtask

  // Inputs must already be applied (called just after a negedge).
  task automatic cycle();
    bit          redir, take;
    logic [31:0] tgt, nxt, nrpc, e_epc;
    logic [1:0]  hz;
    bit          npend, nipend;
    #1;
    redir = BranchTaken | JrEn | JumpEn;
    tgt   = BranchTaken ? BranchTarget : (JrEn ? JrTarget : JumpTarget);
    take  = 0; hz = 2'd0; nxt = m_pc + 32'd4; npend = m_pend; nrpc = m_rpc;
    if (ExcReq) begin
      nxt = EXC_VECTOR; npend = 0; hz = 2'd1;
    end else if (Stall) begin
      nxt = m_pc; hz = 2'd2;
      if (redir) begin npend = 1; nrpc = tgt; end
    end else if (m_pend) begin
      nxt = redir ? tgt : m_rpc; npend = 0; hz = 2'd1;
    end else if (redir) begin
      nxt = tgt; hz = 2'd1;
    end else if (m_ipend && !m_pc[31]) begin
      take = 1; nxt = IRQ_VECTOR; hz = 2'd1;
    end
    e_epc  = take ? m_pc : 32'd0;
    nipend = (m_ipend | (Irq & ~m_pc[31])) & ~take;
    if (m_valid) begin
      chk("pc",       PC,       m_pc);
      chk("imemaddr", ImemAddr, m_pc);
      chk("pc4",      PC4,      m_pc + 32'd4);
      chk("inst",     Inst,     ImemData);
      chk("hzctrl",   {30'd0, HzCtrl}, {30'd0, hz});
      chk("epc_we",   {31'd0, EPC_We}, {31'd0, take});
      chk("epc_out",  EPC_Out,  e_epc);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1; m_pc = RESET_PC; m_pend = 0; m_rpc = 32'd0; m_ipend = 0;
    end else begin
      m_pc = nxt; m_pend = npend; m_rpc = nrpc; m_ipend = nipend;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {$urandom} & 32'h0000_FFFC;
    case ($urandom_range(0, 3))
      0:       return 32'h0040_0000 | a;
      1:       return 32'h8000_0000 | a;
      2:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle_inputs();
    ImemData = 32'h2408_0001;
    @(negedge clk);

    // 1: reset and sequential fetch
    rst = 1; cycle(); rst = 0;
    chk("t1_reset_pc", PC, 32'h8000_0000);
    chk("t1_reset_hz", {30'd0, HzCtrl}, 32'd0);
    repeat (3) cycle();
    chk("t1_pc_seq", PC, 32'h8000_000C);
    cycle();
    chk("t1_pc_10", PC, 32'h8000_0010);

    // 2: jump, then branch beats jr
    JumpEn = 1; JumpTarget = 32'h8000_0100; cycle(); idle_inputs();
    chk("t2_jump", PC, 32'h8000_0100);
    BranchTaken = 1; BranchTarget = 32'h8000_0200; JrEn = 1; JrTarget = 32'h8000_0300;
    cycle(); idle_inputs();
    chk("t2_br_over_jr", PC, 32'h8000_0200);

    // 3: redirect latched during a 3-cycle stall
    Stall = 1; BranchTaken = 1; BranchTarget = 32'h8000_0040; cycle();
    idle_inputs(); Stall = 1; cycle(); cycle();
    chk("t3_held", PC, 32'h8000_0200);
    idle_inputs(); #1;
    chk("t3_release_hz", {30'd0, HzCtrl}, 32'd1);
    cycle();
    chk("t3_redir_pc", PC, 32'h8000_0040);

    // 4: interrupt requested during stall is deferred to first free cycle
    JumpEn = 1; JumpTarget = 32'h0040_0000; cycle(); idle_inputs();
    Stall = 1; Irq = 1; cycle(); Irq = 0; cycle();
    idle_inputs(); #1;
    chk("t4_epc_we", {31'd0, EPC_We}, 32'd1);
    chk("t4_epc_out", EPC_Out, 32'h0040_0000);
    chk("t4_hz", {30'd0, HzCtrl}, 32'd1);
    cycle();
    chk("t4_irq_vec", PC, 32'h8000_0004);

    // 5: exception overrides stall and drops pending redirect
    Stall = 1; JumpEn = 1; JumpTarget = 32'h8000_0500; cycle(); idle_inputs();
    Stall = 1; ExcReq = 1; cycle(); idle_inputs();
    chk("t5_exc_vec", PC, 32'h8000_0008);
    Stall = 1; cycle(); idle_inputs(); cycle();
    chk("t5_no_stale", PC, 32'h8000_000C);

    // 6: reset mid-stall clears pending state; PC wraps at the top
    JumpEn = 1; JumpTarget = 32'h0040_0000; cycle(); idle_inputs();
    Stall = 1; Irq = 1; JumpEn = 1; JumpTarget = 32'h8000_0600; cycle(); idle_inputs();
    Stall = 1; rst = 1; cycle(); idle_inputs();
    chk("t6_reset_pc", PC, 32'h8000_0000);
    JumpEn = 1; JumpTarget = 32'h0040_0000; cycle(); idle_inputs();
    cycle();
    chk("t6_no_irq", PC, 32'h0040_0004);
    JumpEn = 1; JumpTarget = 32'hFFFF_FFFC; cycle(); idle_inputs();
    chk("t6_pc4_wrap", PC4, 32'h0000_0000);
    cycle();
    chk("t6_pc_wrap", PC, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      Stall        = ($urandom_range(0, 3) == 0);
      BranchTaken  = ($urandom_range(0, 7) == 0);
      JumpEn       = ($urandom_range(0, 7) == 0);
      JrEn         = ($urandom_range(0, 9) == 0);
      ExcReq       = ($urandom_range(0, 29) == 0);
      Irq          = ($urandom_range(0, 5) == 0);
      BranchTarget = rnd_addr();
      JumpTarget   = rnd_addr();
      JrTarget     = rnd_addr();
      ImemData     = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
